// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed seven-segment scanner.
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic {GAP, SHOW} scan_state_t;

  typedef logic [3:0] bcd_t;

endpackage

// File: rtl/seg_slot_timer.sv
// Slot prescaler: counts 0..DIV-1, pulses slot_end on the last count of a slot.
// in_gap looks one cycle ahead (the count being loaded next) so the registered anode outputs line up with the count.
module seg_slot_timer #(
  parameter int DIV = 50000,
  parameter int GAP = 16
) (
  input  logic clk,
  input  logic reset,
  output logic slot_end,
  output logic in_gap
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign slot_end = (cnt_q == CW'(DIV - 1));
  assign cnt_d    = slot_end ? '0 : cnt_q + 1'b1;

  generate
    if (GAP == 0) begin : g_nogap
      assign in_gap = 1'b0;
    end else begin : g_gap
      assign in_gap = (cnt_d < CW'(GAP));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan.sv
// Scans NDIG stored BCD digits onto one shared decoder with active-low anodes and an anti-ghost gap.
// Build option SEG_SCAN_LZB_EN: leading-zero blanking applied when bcd_in is captured.
module seg_scan #(
  parameter int NDIG = 4,
  parameter int DIV  = 50000,
  parameter int GAP  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [3:0]        y,
  output logic [NDIG-1:0]   an,
  output logic [2:0]        idx
);

  import seg_pkg::*;

  bcd_t        disp_q [NDIG];
  bcd_t        cap_d  [NDIG];
  logic        slot_end;
  logic        in_gap;
  scan_state_t state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  bcd_t        y_q, y_d;
  logic [NDIG-1:0] an_q, an_d;

  seg_slot_timer #(.DIV(DIV), .GAP(GAP)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .slot_end (slot_end),
    .in_gap   (in_gap)
  );

`ifdef SEG_SCAN_LZB_EN
  logic lead;
`endif

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      cap_d[i] = bcd_in[4*i +: 4];
    end
`ifdef SEG_SCAN_LZB_EN
    // Blank zeros from the top down until the first nonzero; digit 0 always shows.
    lead = 1'b1;
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (lead && cap_d[i] == 4'd0) begin
        cap_d[i] = BLANK_CODE;
      end else begin
        lead = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == 3'(NDIG - 1)) ? 3'd0 : idx_q + 3'd1;
    end

    state_d = state_q;
    case (state_q)
      seg_pkg::GAP:  state_d = in_gap ? seg_pkg::GAP : seg_pkg::SHOW;
      seg_pkg::SHOW: state_d = (slot_end && in_gap) ? seg_pkg::GAP : seg_pkg::SHOW;
      default:       state_d = seg_pkg::GAP;
    endcase

    // Code follows the upcoming idx so it settles before that digit's anode lights.
    y_d  = BLANK_CODE;
    an_d = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (idx_d == 3'(i)) begin
        y_d = disp_q[i];
        if (state_d == seg_pkg::SHOW) begin
          an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) begin
        disp_q[i] <= BLANK_CODE;
      end
      idx_q   <= 3'd0;
      state_q <= seg_pkg::GAP;
      y_q     <= BLANK_CODE;
      an_q    <= '1;
    end else begin
      if (load) begin
        disp_q <= cap_d;
      end
      idx_q   <= idx_d;
      state_q <= state_d;
      y_q     <= y_d;
      an_q    <= an_d;
    end
  end

  assign y   = y_q;
  assign an  = an_q;
  assign idx = idx_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan (NDIG=4, DIV=8, GAP=2) with a per-cycle expected-output scoreboard.
module tb_seg_scan;

  localparam int NDIG = 4;
  localparam int DIV  = 8;
  localparam int GAP  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  y;
  logic [3:0]  an;
  logic [2:0]  idx;

  always #5 clk = ~clk;

  seg_scan #(.NDIG(NDIG), .DIV(DIV), .GAP(GAP)) dut (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .bcd_in (bcd_in),
    .y      (y),
    .an     (an),
    .idx    (idx)
  );

  typedef struct {
    logic [3:0] y;
    logic [3:0] an;
    logic [2:0] idx;
  } exp_t;

  exp_t       sb_q[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         t      = 0;
  logic [3:0] m_disp [NDIG];

  function automatic logic [15:0] capture(input logic [15:0] v);
    logic [15:0] r;
    r = v;
`ifdef SEG_SCAN_LZB_EN
    for (int i = NDIG - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) break;
      r[4*i +: 4] = 4'hF;
    end
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
  endtask

  // One clock: drive inputs, push the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic r, input logic ld, input logic [15:0] v);
    exp_t e;
    exp_t got;
    logic [15:0] c;
    int cnt;
    int mi;
    reset  = r;
    load   = ld;
    bcd_in = v;
    if (r) begin
      t = 0;
      for (int i = 0; i < NDIG; i++) m_disp[i] = 4'hF;
      e.y = 4'hF; e.an = 4'hF; e.idx = 3'd0;
    end else begin
      t++;
      cnt   = t % DIV;
      mi    = (t / DIV) % NDIG;
      e.idx = 3'(mi);
      e.an  = (cnt < GAP) ? 4'hF : ~(4'b0001 << mi);
      e.y   = m_disp[mi];
      if (ld) begin
        c = capture(v);
        for (int i = 0; i < NDIG; i++) m_disp[i] = c[4*i +: 4];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("y",   32'(y),   32'(got.y));
    check("an",  32'(an),  32'(got.an));
    check("idx", 32'(idx), 32'(got.idx));
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  // Advance until the next edge lands on digit d at prescaler count c (bounded).
  task automatic run_to(input int d, input int c);
    int k;
    k = 0;
    while (!((((t + 1) / DIV) % NDIG == d) && ((t + 1) % DIV == c)) && k < 64) begin
      step(1'b0, 1'b0, 16'h0);
      k++;
    end
    check("run_to_reached", 32'(k < 64), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    load   = 1'b0;
    bcd_in = 16'h0;
    for (int i = 0; i < NDIG; i++) m_disp[i] = 4'hF;

    // Reset held 3 cycles.
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    check("reset_y",   32'(y),   32'hF);
    check("reset_an",  32'(an),  32'hF);
    check("reset_idx", 32'(idx), 32'd0);

    // Release with a 1234 load; first lit anode exactly GAP cycles later.
    step(1'b0, 1'b1, 16'h1234);
    check("gap_an", 32'(an), 32'hF);
    step(1'b0, 1'b0, 16'h0);
    check("first_show_an", 32'(an), 32'b1110);
    check("first_show_y",  32'(y),  32'h4);
    run(4 * DIV);

    // Mid-SHOW load on digit 2.
    run_to(2, 4);
    step(1'b0, 1'b1, 16'h0900);
    step(1'b0, 1'b0, 16'h0);
    check("load_lat_y",   32'(y),   32'h9);
    check("load_lat_an",  32'(an),  32'b1011);
    check("load_lat_idx", 32'(idx), 32'd2);
    run(20);

    // Reset during SHOW of digit 3.
    run_to(3, 5);
    step(1'b1, 1'b0, 16'h0);
    check("mid_reset_an",  32'(an),  32'hF);
    check("mid_reset_y",   32'(y),   32'hF);
    check("mid_reset_idx", 32'(idx), 32'd0);
    run(20);

    // Leading-zero patterns (blanked only when the macro is defined).
    step(1'b0, 1'b1, 16'h0050);
    run(4 * DIV + 2);
    step(1'b0, 1'b1, 16'h0000);
    run(4 * DIV + 2);

    // Codes above 9 pass through untouched.
    step(1'b0, 1'b1, 16'hABCD);
    run(4 * DIV + 2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
